// File: rtl/equiv_lockstep_sequencer_if.sv
// Stimulus/compare bus between the lockstep sequencer and the equivalence top.
// The sequencer is the master; the harness driving start/seed and feeding back both copies is the slave.
interface equiv_lockstep_sequencer_if #(
    parameter int IN_W  = 57,
    parameter int OUT_W = 91
);
    logic             start;
    logic [63:0]      seed;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] y_1;
    logic [OUT_W-1:0] y_2;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [31:0]      fail_cycle;
    logic [OUT_W-1:0] mismatch_bits;
    logic [31:0]      cycle_cnt;

    modport master (
        input  start, seed, y_1, y_2,
        output stim, busy, done, pass, fail, fail_cycle, mismatch_bits, cycle_cnt
    );

    modport slave (
        output start, seed, y_1, y_2,
        input  stim, busy, done, pass, fail, fail_cycle, mismatch_bits, cycle_cnt
    );
endinterface

// File: rtl/equiv_lockstep_sequencer.sv
// Drives two lockstep DUT copies from one LFSR stimulus stream and compares their outputs,
// stopping at the first miscompare or after MAX_CYCLES clean compares.
module equiv_lockstep_sequencer #(
    parameter int IN_W       = 57,
    parameter int OUT_W      = 91,
    parameter int WARMUP     = 4,
    parameter int MAX_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    equiv_lockstep_sequencer_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_DONE} state_e;

    state_e           state_q;
    logic [63:0]      lfsr_q;
    logic [63:0]      lfsr_d;
    logic [IN_W-1:0]  stim_q;
    logic [31:0]      warm_q;
    logic [31:0]      cycle_cnt_q;
    logic [31:0]      cycle_cnt_d;
    logic [31:0]      fail_cycle_q;
    logic [OUT_W-1:0] mismatch_q;
    logic [OUT_W-1:0] diff_d;
    logic             pass_q;
    logic             fail_q;
    logic             start_ok_d;
    logic             last_d;

    // Fibonacci LFSR, taps 64,63,61,60, shifting left with feedback into bit 0.
    assign lfsr_d      = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
    assign diff_d      = bus.y_1 ^ bus.y_2;
    assign start_ok_d  = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign cycle_cnt_d = (cycle_cnt_q == 32'hFFFF_FFFF) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
    assign last_d      = (cycle_cnt_q == 32'(MAX_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lfsr_q       <= 64'h1;
            stim_q       <= '0;
            warm_q       <= '0;
            cycle_cnt_q  <= '0;
            fail_cycle_q <= '0;
            mismatch_q   <= '0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else if (start_ok_d) begin
            lfsr_q       <= (bus.seed == 64'h0) ? 64'h1 : bus.seed;
            warm_q       <= '0;
            cycle_cnt_q  <= '0;
            fail_cycle_q <= '0;
            mismatch_q   <= '0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            state_q      <= (WARMUP == 0) ? S_RUN : S_WARMUP;
        end else begin
            case (state_q)
                S_WARMUP: begin
                    lfsr_q <= lfsr_d;
                    stim_q <= lfsr_d[IN_W-1:0];
                    if (warm_q == 32'(WARMUP - 1)) begin
                        state_q <= S_RUN;
                    end else begin
                        warm_q <= warm_q + 32'd1;
                    end
                end
                S_RUN: begin
                    lfsr_q      <= lfsr_d;
                    stim_q      <= lfsr_d[IN_W-1:0];
                    cycle_cnt_q <= cycle_cnt_d;
                    // A miscompare takes priority, including on the final compare index.
                    if (diff_d != '0) begin
                        fail_q       <= 1'b1;
                        fail_cycle_q <= cycle_cnt_q;
                        mismatch_q   <= diff_d;
                        state_q      <= S_DONE;
                    end else if (last_d) begin
                        pass_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.stim          = stim_q;
    assign bus.busy          = (state_q == S_WARMUP) || (state_q == S_RUN);
    assign bus.done          = (state_q == S_DONE);
    assign bus.pass          = pass_q;
    assign bus.fail          = fail_q;
    assign bus.fail_cycle    = fail_cycle_q;
    assign bus.mismatch_bits = mismatch_q;
    assign bus.cycle_cnt     = cycle_cnt_q;
endmodule

// File: tb/tb_equiv_lockstep_sequencer.sv
// Scoreboard bench for equiv_lockstep_sequencer: two modelled DUT copies, one with a
// programmable single-cycle bit flip, and an independent LFSR model for the stimulus.
module tb_equiv_lockstep_sequencer;
    localparam int IN_W       = 57;
    localparam int OUT_W      = 91;
    localparam int WARMUP     = 4;
    localparam int MAX_CYCLES = 16;

    typedef struct {
        logic             pass;
        logic             fail;
        logic [31:0]      failCycle;
        logic [OUT_W-1:0] mism;
        logic [31:0]      cnt;
    } expT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int edgeNo = 0;
    int injIdx = -1;
    logic [OUT_W-1:0] injMask = '0;
    logic [OUT_W-1:0] yBase;
    logic injOn;
    expT expQ[$];

    equiv_lockstep_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    equiv_lockstep_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .WARMUP(WARMUP), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // The two DUT copies: a simple function of the stimulus, with copy 2 corrupted
    // on exactly one compare index (edgeNo is the number of the upcoming edge since start).
    assign yBase     = {bus.stim, bus.stim[33:0]};
    assign injOn     = (injIdx >= 0) && ((edgeNo - 1 - WARMUP) == injIdx);
    assign bus.y_1   = yBase;
    assign bus.y_2   = yBase ^ (injOn ? injMask : '0);

    function automatic logic [63:0] lfsrNext(input logic [63:0] v);
        return {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "Flags"}, {bus.busy, bus.done, bus.pass, bus.fail}, 4'b0000);
        checkOutput({tag, "Stim"}, bus.stim, 0);
        checkOutput({tag, "Cnt"}, bus.cycle_cnt, 0);
        checkOutput({tag, "FailCyc"}, bus.fail_cycle, 0);
        checkOutput({tag, "Mism"}, bus.mismatch_bits, 0);
    endtask

    // Starts a run, pushes its expected verdict, follows the stimulus edge by edge against
    // the LFSR model, then pops and compares the verdict once done rises. pokeAt issues an
    // extra start while busy; rstAt asserts reset before that edge and abandons the run.
    task automatic applyStimulus(input logic [63:0] seedV, input int injI, input logic [OUT_W-1:0] injM,
                                 input int pokeAt, input int rstAt);
        expT e;
        logic [63:0] model;
        int edges;
        bit seen;
        model = (seedV == 64'h0) ? 64'h1 : seedV;
        if (injI >= 0 && injI < MAX_CYCLES) begin
            e.pass = 1'b0; e.fail = 1'b1; e.failCycle = injI; e.mism = injM; e.cnt = injI + 1;
        end else begin
            e.pass = 1'b1; e.fail = 1'b0; e.failCycle = 0; e.mism = '0; e.cnt = MAX_CYCLES;
        end
        if (rstAt == 0) expQ.push_back(e);
        injIdx  = injI;
        injMask = injM;
        bus.seed  = seedV;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        edgeNo = 1;
        checkOutput("startFlags", {bus.busy, bus.done, bus.pass, bus.fail}, 4'b1000);
        checkOutput("startCnt", bus.cycle_cnt, 0);
        checkOutput("startFailCyc", bus.fail_cycle, 0);
        checkOutput("startMism", bus.mismatch_bits, 0);
        seen  = 0;
        edges = 0;
        for (int n = 1; n <= 200 && !seen; n++) begin
            if (n == pokeAt) begin
                bus.seed  = 64'h1234_5678;
                bus.start = 1'b1;
            end
            if (n == rstAt) rst = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            edgeNo = n + 1;
            model = lfsrNext(model);
            if (n == rstAt) begin
                rst = 1'b0;
                injIdx = -1;
                checkIdle("midRst");
                return;
            end
            checkOutput("stim", bus.stim, model[IN_W-1:0]);
            if (bus.done) begin
                seen  = 1;
                edges = n;
            end else begin
                checkOutput("busyFlags", {bus.busy, bus.done, bus.pass, bus.fail}, 4'b1000);
            end
        end
        injIdx = -1;
        e = expQ.pop_front();
        if (!seen) begin
            checkOutput("doneTimeout", 0, 1);
            return;
        end
        checkOutput("runLen", edges, WARMUP + e.cnt);
        checkOutput("doneFlags", {bus.busy, bus.done, bus.pass, bus.fail}, {2'b01, e.pass, e.fail});
        checkOutput("cycleCnt", bus.cycle_cnt, e.cnt);
        checkOutput("failCycle", bus.fail_cycle, e.failCycle);
        checkOutput("mismBits", bus.mismatch_bits, e.mism);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("holdStim", bus.stim, model[IN_W-1:0]);
        checkOutput("holdFlags", {bus.busy, bus.done, bus.pass, bus.fail}, {2'b01, e.pass, e.fail});
        checkOutput("holdCnt", bus.cycle_cnt, e.cnt);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.seed  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkIdle("reset");

        applyStimulus(64'hDEAD_BEEF, -1, '0, 0, 0);
        applyStimulus(64'hDEAD_BEEF, 5, 91'h80, 0, 0);
        applyStimulus(64'hDEAD_BEEF, -1, '0, 0, 0);
        applyStimulus(64'h00C0_FFEE, MAX_CYCLES - 1, {1'b1, 90'b0}, 0, 0);
        applyStimulus(64'h0, -1, '0, 0, 0);
        applyStimulus(64'h0, -1, '0, 0, 0);
        applyStimulus(64'hABCD_0123, -1, '0, 2, 0);
        applyStimulus(64'h5555_AAAA, -1, '0, 12, 0);
        applyStimulus(64'h5555_AAAA, -1, '0, 0, WARMUP + 1 + 3);
        applyStimulus(64'h77, 3, 91'h5_0000_0000_0000_0003, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
